// File: rtl/ram_pattern_checker.sv
// Wishbone RAM test master: writes an index/pass-dependent pattern over a window, reads it back,
// compares. Define RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN to count mismatches instead of halting.
module ram_pattern_checker #(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter logic [31:0] PATTERN_MULT = 32'h9E3779B1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  leds,
  output logic        wbCycleStrobe,
  output logic        wbWriteEnable,
  output logic [31:0] wbAddress,
  output logic [31:0] wbWriteData,
  input  logic [31:0] wbReadData,
  input  logic        wbAck,
  output logic [7:0]  passCount,
  output logic [15:0] errorCount
);

  typedef enum logic [1:0] {StWrite, StRead, StHalt} state_e;

  localparam logic [ADDRESS_BITS-1:0] IdxOne = ADDRESS_BITS'(1);

  function automatic logic [31:0] pattern(input logic [ADDRESS_BITS-1:0] idx,
                                          input logic [7:0] pass);
    logic [31:0] prod;
    prod = 32'(idx) * PATTERN_MULT;
    return prod ^ {4{pass}};
  endfunction

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] idx_q, idx_d;
  logic [7:0]              pass_q, pass_d;
  logic                    hb_q, hb_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
`ifdef RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN
  logic                    err_led_q, err_led_d;
`endif

  logic        xfer, last, mismatch, advance;
  logic [31:0] idx_ext;
  logic [7:0]  leds_d;
  logic        strobe_d, we_d;
  logic [31:0] addr_d, data_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    hb_d      = hb_q;
    err_cnt_d = err_cnt_q;
`ifdef RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN
    err_led_d = err_led_q;
`endif
    advance   = 1'b0;
    xfer      = wbCycleStrobe && wbAck;
    last      = &idx_q;
    mismatch  = wbReadData != pattern(idx_q, pass_q);

    unique case (state_q)
      StWrite: begin
        if (xfer) begin
          if (last) begin
            idx_d   = '0;
            state_d = StRead;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      StRead: begin
        if (xfer) begin
`ifdef RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN
          if (mismatch) begin
            err_led_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          advance = 1'b1;
`else
          // idx_q stays frozen and serves as the latched failing index
          if (mismatch) begin
            err_cnt_d = 16'd1;
            state_d   = StHalt;
          end else begin
            advance = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase

    if (advance) begin
      if (last) begin
        idx_d   = '0;
        pass_d  = pass_q + 8'd1;
        hb_d    = ~hb_q;
        state_d = StWrite;
      end else begin
        idx_d = idx_q + IdxOne;
      end
    end

    // Outputs are registered from the next state so they change the cycle after the ack edge
    idx_ext  = 32'(idx_d);
    strobe_d = state_d != StHalt;
    we_d     = state_d == StWrite;
    addr_d   = idx_ext;
    data_d   = (state_d == StWrite) ? pattern(idx_d, pass_d) : 32'd0;
    if (state_d == StHalt) begin
      leds_d = {1'b1, idx_ext[6:0]};
    end else begin
`ifdef RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN
      leds_d = {err_led_d, hb_d, pass_d[5:0]};
`else
      leds_d = {1'b0, hb_d, pass_d[5:0]};
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StWrite;
      idx_q         <= '0;
      pass_q        <= '0;
      hb_q          <= 1'b0;
      err_cnt_q     <= '0;
`ifdef RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN
      err_led_q     <= 1'b0;
`endif
      leds          <= '0;
      wbCycleStrobe <= 1'b0;
      wbWriteEnable <= 1'b0;
      wbAddress     <= '0;
      wbWriteData   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pass_q        <= pass_d;
      hb_q          <= hb_d;
      err_cnt_q     <= err_cnt_d;
`ifdef RAM_PATTERN_CHECKER_CONTINUE_ON_ERROR_EN
      err_led_q     <= err_led_d;
`endif
      leds          <= leds_d;
      wbCycleStrobe <= strobe_d;
      wbWriteEnable <= we_d;
      wbAddress     <= addr_d;
      wbWriteData   <= data_d;
    end
  end

  assign passCount  = pass_q;
  assign errorCount = err_cnt_q;

endmodule
